// File: rtl/fractal_core_scheduler.sv
// Raster-scans a frame, hands pixel jobs to free iteration cores round-robin and
// merges their tagged results into a single valid/ready pixel stream.
module fractal_core_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int COORD_W   = 10,
    parameter int ITER_W    = 11
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [COORD_W-1:0]            job_x,
    output logic [COORD_W-1:0]            job_y,
    output logic [NUM_CORES-1:0]          core_start,
    input  logic [NUM_CORES-1:0]          core_busy,
    input  logic [NUM_CORES-1:0]          core_result_valid,
    output logic [NUM_CORES-1:0]          core_result_read,
    input  logic [NUM_CORES*ITER_W-1:0]   core_iter,
    input  logic [NUM_CORES-1:0]          core_in_set,
    output logic [COORD_W-1:0]            pix_x,
    output logic [COORD_W-1:0]            pix_y,
    output logic [ITER_W-1:0]             pix_iter,
    output logic                          pix_in_set,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          err_spurious
);
    // state    | meaning
    // S_IDLE   | waiting for start
    // S_DISPATCH | issuing raster jobs to free cores
    // S_DRAIN  | all jobs issued, waiting for results and output register to empty
    // S_DONE   | one-cycle completion pulse
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [NUM_CORES-1:0] owned_q, owned_d;
    logic [COORD_W-1:0]   slot_x_q [NUM_CORES];
    logic [COORD_W-1:0]   slot_x_d [NUM_CORES];
    logic [COORD_W-1:0]   slot_y_q [NUM_CORES];
    logic [COORD_W-1:0]   slot_y_d [NUM_CORES];
    logic [PW-1:0]        disp_ptr_q, disp_ptr_d, coll_ptr_q, coll_ptr_d;
    logic [COORD_W-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [ITER_W-1:0]    pix_iter_q, pix_iter_d;
    logic                 pix_in_set_q, pix_in_set_d, pix_valid_q, pix_valid_d;
    logic                 err_q, err_d;

    logic [NUM_CORES-1:0] free, elig;
    logic                 disp_found, coll_found, loadable;
    logic [PW-1:0]        disp_idx, coll_idx, d_cand, c_cand;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = 32'(base);
        s = s + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return PW'(s);
    endfunction

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        owned_d      = owned_q;
        slot_x_d     = slot_x_q;
        slot_y_d     = slot_y_q;
        disp_ptr_d   = disp_ptr_q;
        coll_ptr_d   = coll_ptr_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_iter_d   = pix_iter_q;
        pix_in_set_d = pix_in_set_q;
        pix_valid_d  = pix_valid_q;
        core_start       = '0;
        core_result_read = '0;
        job_x        = '0;
        job_y        = '0;
        disp_found   = 1'b0;
        coll_found   = 1'b0;
        disp_idx     = '0;
        coll_idx     = '0;
        d_cand       = '0;
        c_cand       = '0;

        free     = ~owned_q & ~core_busy;
        elig     = core_result_valid & owned_q;
        loadable = !pix_valid_q || pix_ready;
        err_d    = err_q | (|(core_result_valid & ~owned_q));

        for (int i = 0; i < NUM_CORES; i++) begin
            d_cand = rr_idx(disp_ptr_q, i);
            if (!disp_found && free[d_cand]) begin
                disp_found = 1'b1;
                disp_idx   = d_cand;
            end
            c_cand = rr_idx(coll_ptr_q, i);
            if (!coll_found && elig[c_cand]) begin
                coll_found = 1'b1;
                coll_idx   = c_cand;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DISPATCH;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_DISPATCH: begin
                if (disp_found) begin
                    core_start[disp_idx] = 1'b1;
                    job_x                = x_q;
                    job_y                = y_q;
                    slot_x_d[disp_idx]   = x_q;
                    slot_y_d[disp_idx]   = y_q;
                    owned_d[disp_idx]    = 1'b1;
                    disp_ptr_d           = rr_idx(disp_idx, 1);
                    if (x_q == COORD_W'(H_RES - 1)) begin
                        x_d = '0;
                        if (y_q == COORD_W'(V_RES - 1)) begin
                            y_d     = '0;
                            state_d = S_DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (owned_q == '0 && !pix_valid_q) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Collection runs in every state; eligibility needs ownership, so idle cores are never read.
        if (pix_valid_q && pix_ready) pix_valid_d = 1'b0;
        if (loadable && coll_found) begin
            core_result_read[coll_idx] = 1'b1;
            pix_x_d           = slot_x_q[coll_idx];
            pix_y_d           = slot_y_q[coll_idx];
            pix_iter_d        = core_iter[coll_idx*ITER_W +: ITER_W];
            pix_in_set_d      = core_in_set[coll_idx];
            pix_valid_d       = 1'b1;
            owned_d[coll_idx] = 1'b0;
            coll_ptr_d        = rr_idx(coll_idx, 1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            owned_q      <= '0;
            disp_ptr_q   <= '0;
            coll_ptr_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_iter_q   <= '0;
            pix_in_set_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_x_q[i] <= '0;
                slot_y_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            owned_q      <= owned_d;
            disp_ptr_q   <= disp_ptr_d;
            coll_ptr_q   <= coll_ptr_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_iter_q   <= pix_iter_d;
            pix_in_set_q <= pix_in_set_d;
            pix_valid_q  <= pix_valid_d;
            err_q        <= err_d;
            slot_x_q     <= slot_x_d;
            slot_y_q     <= slot_y_d;
        end
    end

    assign busy         = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_iter     = pix_iter_q;
    assign pix_in_set   = pix_in_set_q;
    assign pix_valid    = pix_valid_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_fractal_core_scheduler.sv
// Bench for fractal_core_scheduler: fixed-latency core models echo their job coordinates
// into the result, and a cycle monitor checks raster order, tagging, stalls and completion.
module tb_fractal_core_scheduler;
    localparam int NC = 2;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CW = 3;
    localparam int IW = 8;

    logic              clock, reset_n, start, busy, done;
    logic [CW-1:0]     job_x, job_y, pix_x, pix_y;
    logic [NC-1:0]     core_start, core_busy, core_result_valid, core_result_read, core_in_set;
    logic [NC*IW-1:0]  core_iter;
    logic [IW-1:0]     pix_iter;
    logic              pix_in_set, pix_valid, pix_ready, err_spurious;

    fractal_core_scheduler #(.NUM_CORES(NC), .H_RES(H), .V_RES(V), .COORD_W(CW), .ITER_W(IW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .job_x(job_x), .job_y(job_y), .core_start(core_start), .core_busy(core_busy),
        .core_result_valid(core_result_valid), .core_result_read(core_result_read),
        .core_iter(core_iter), .core_in_set(core_in_set), .pix_x(pix_x), .pix_y(pix_y),
        .pix_iter(pix_iter), .pix_in_set(pix_in_set), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .err_spurious(err_spurious));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [IW-1:0] exp_iter(input int x, input int y);
        return IW'(x * 37 + y * 11 + 5);
    endfunction
    function automatic logic exp_inset(input int x, input int y);
        return ((x + y) % 2) == 1;
    endfunction

    // Core models: busy for lat cycles after a launch, then hold the result until read.
    logic [NC-1:0] cbusy, cvalid, force_vec;
    int            ccnt [NC];
    logic [CW-1:0] cx [NC];
    logic [CW-1:0] cy [NC];
    int            lat [NC];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cbusy  <= '0;
            cvalid <= '0;
            for (int i = 0; i < NC; i++) begin
                ccnt[i] <= 0;
                cx[i]   <= '0;
                cy[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    cx[i]    <= job_x;
                    cy[i]    <= job_y;
                    ccnt[i]  <= lat[i] - 1;
                    cbusy[i] <= 1'b1;
                end else if (cbusy[i]) begin
                    if (ccnt[i] == 0) begin
                        cbusy[i]  <= 1'b0;
                        cvalid[i] <= 1'b1;
                    end else begin
                        ccnt[i] <= ccnt[i] - 1;
                    end
                end
                if (core_result_read[i]) cvalid[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        core_iter         = '0;
        core_in_set       = '0;
        core_result_valid = cvalid | force_vec;
        for (int i = 0; i < NC; i++) begin
            core_iter[i*IW +: IW] = exp_iter(int'(cx[i]), int'(cy[i]));
            core_in_set[i]        = exp_inset(int'(cx[i]), int'(cy[i]));
        end
    end
    assign core_busy = cbusy;

    typedef struct {
        int lat0;
        int lat1;
        int stall_at;
        int stall_len;
        bit rnd_ready;
        bit extra_start;
        bit chk_alt;
        bit chk_c1_more;
        int exp_issues;
        int exp_done;
        int exp_err;
    } vec_t;

    vec_t vecs [7];
    int   checks, errors;

    int            issue_idx, pix_cnt, done_cnt, last_core;
    int            starts_core [NC];
    int            seen [64];
    bit            prev_busy, prev_stall, prev_read, chk_alt_en, alt_prev_valid;
    logic [CW-1:0] held_x, held_y;
    logic [IW-1:0] held_iter;
    logic          held_inset;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        int which;
        if (!reset_n) begin
            prev_busy  = 0;
            prev_stall = 0;
            prev_read  = 0;
            issue_idx  = 0;
            return;
        end
        if (busy && !prev_busy) begin
            issue_idx      = 0;
            alt_prev_valid = 0;
        end
        if (core_start != '0) begin
            which = 0;
            for (int i = 0; i < NC; i++) if (core_start[i]) which = i;
            chk_eq("start_onehot", int'($onehot(core_start)), 1);
            chk_eq("issue_in_frame", int'(issue_idx < H * V), 1);
            chk_eq("job_x", int'(job_x), issue_idx % H);
            chk_eq("job_y", int'(job_y), issue_idx / H);
            if (chk_alt_en && alt_prev_valid) chk_eq("start_alternates", which, (last_core + 1) % NC);
            last_core      = which;
            alt_prev_valid = 1;
            starts_core[which]++;
            issue_idx++;
        end
        if (prev_read) chk_eq("read_to_valid", int'(pix_valid), 1);
        if (prev_stall) begin
            chk_eq("stall_valid", int'(pix_valid), 1);
            chk_eq("stall_x", int'(pix_x), int'(held_x));
            chk_eq("stall_y", int'(pix_y), int'(held_y));
            chk_eq("stall_iter", int'(pix_iter), int'(held_iter));
            chk_eq("stall_inset", int'(pix_in_set), int'(held_inset));
        end
        if (pix_valid && !pix_ready) chk_eq("read_while_full", int'(core_result_read), 0);
        if (cvalid != '0 && (!pix_valid || pix_ready))
            chk_eq("read_when_loadable", int'(core_result_read != '0), 1);
        if (core_result_read != '0) begin
            chk_eq("read_onehot", int'($onehot(core_result_read)), 1);
            chk_eq("read_has_result", int'(core_result_read & ~cvalid), 0);
        end
        if (pix_valid) begin
            chk_eq("pix_iter_echo", int'(pix_iter), int'(exp_iter(int'(pix_x), int'(pix_y))));
            chk_eq("pix_inset_echo", int'(pix_in_set), int'(exp_inset(int'(pix_x), int'(pix_y))));
            if (pix_ready) begin
                seen[int'(pix_y) * 8 + int'(pix_x)]++;
                pix_cnt++;
            end
        end
        if (done) begin
            done_cnt++;
            chk_eq("busy_low_at_done", int'(busy), 0);
            chk_eq("busy_before_done", int'(prev_busy), 1);
        end
        prev_busy  = busy;
        prev_stall = pix_valid && !pix_ready;
        prev_read  = core_result_read != '0;
        held_x     = pix_x;
        held_y     = pix_y;
        held_iter  = pix_iter;
        held_inset = pix_in_set;
    endtask

    task automatic cycle();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk_eq({tag, "_busy"}, int'(busy), 0);
        chk_eq({tag, "_done"}, int'(done), 0);
        chk_eq({tag, "_job_x"}, int'(job_x), 0);
        chk_eq({tag, "_job_y"}, int'(job_y), 0);
        chk_eq({tag, "_core_start"}, int'(core_start), 0);
        chk_eq({tag, "_result_read"}, int'(core_result_read), 0);
        chk_eq({tag, "_pix_x"}, int'(pix_x), 0);
        chk_eq({tag, "_pix_y"}, int'(pix_y), 0);
        chk_eq({tag, "_pix_iter"}, int'(pix_iter), 0);
        chk_eq({tag, "_pix_in_set"}, int'(pix_in_set), 0);
        chk_eq({tag, "_pix_valid"}, int'(pix_valid), 0);
        chk_eq({tag, "_err"}, int'(err_spurious), 0);
    endtask

    task automatic run_frame(input vec_t v);
        int s_b [NC];
        int seen_b [64];
        int pix_b, done_b, n;
        lat[0]     = v.lat0;
        lat[1]     = v.lat1;
        chk_alt_en = v.chk_alt;
        for (int i = 0; i < NC; i++) s_b[i] = starts_core[i];
        for (int i = 0; i < 64; i++) seen_b[i] = seen[i];
        pix_b  = pix_cnt;
        done_b = done_cnt;
        pix_ready = 1'b1;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        chk_eq("busy_after_start", int'(busy), 1);
        n = 0;
        while (done_cnt == done_b && n < 400) begin
            if (v.rnd_ready) pix_ready = 1'($urandom_range(0, 1));
            else pix_ready = !(v.stall_len > 0 && n >= v.stall_at && n < v.stall_at + v.stall_len);
            start = v.extra_start && (n == 3 || n == 9);
            cycle();
            n++;
        end
        start     = 1'b0;
        pix_ready = 1'b1;
        if (done_cnt == done_b) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no done after %0d cycles", n);
        end
        repeat (5) cycle();
        chk_eq("frame_issues", starts_core[0] + starts_core[1] - s_b[0] - s_b[1], v.exp_issues);
        chk_eq("frame_pixels", pix_cnt - pix_b, H * V);
        chk_eq("frame_done_pulses", done_cnt - done_b, v.exp_done);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                chk_eq("pixel_once", seen[y*8+x] - seen_b[y*8+x], 1);
        chk_eq("idle_busy", int'(busy), 0);
        chk_eq("idle_pix_valid", int'(pix_valid), 0);
        chk_eq("err_state", int'(err_spurious), v.exp_err);
        if (v.chk_c1_more)
            chk_eq("core1_more_jobs", int'((starts_core[1] - s_b[1]) > (starts_core[0] - s_b[0])), 1);
        chk_alt_en = 0;
    endtask

    task automatic reset_mid_frame();
        int s0, n;
        lat[0] = 5;
        lat[1] = 5;
        s0 = starts_core[0] + starts_core[1];
        pix_ready = 1'b1;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (starts_core[0] + starts_core[1] - s0 < 3 && n < 60) begin
            cycle();
            n++;
        end
        chk_eq("three_issues_before_reset", starts_core[0] + starts_core[1] - s0, 3);
        reset_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic spurious_test();
        chk_eq("err_before_force", int'(err_spurious), 0);
        force_vec = 2'b10;
        cycle();
        repeat (4) begin
            chk_eq("spur_core1_read", int'(core_result_read[1]), 0);
            chk_eq("spur_err_set", int'(err_spurious), 1);
            cycle();
        end
        force_vec = '0;
        repeat (5) cycle();
        chk_eq("spur_err_sticky", int'(err_spurious), 1);
    endtask

    initial begin
        vec_t v;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;
        force_vec = '0;
        lat[0]    = 5;
        lat[1]    = 5;
        issue_idx = 0;
        pix_cnt   = 0;
        done_cnt  = 0;
        last_core = 0;
        prev_busy = 0;
        prev_stall = 0;
        prev_read = 0;
        chk_alt_en = 0;
        alt_prev_valid = 0;
        for (int i = 0; i < NC; i++) starts_core[i] = 0;
        for (int i = 0; i < 64; i++) seen[i] = 0;

        //        lat0 lat1 st_at st_len rnd xstart alt c1more issues done err
        vecs[0] = '{5, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 1, 0};
        vecs[1] = '{9, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1, 0};
        vecs[2] = '{5, 5, 6, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1, 0};
        vecs[3] = '{4, 6, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1, 0};
        for (int k = 4; k < 7; k++)
            vecs[k] = '{int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 0, 0,
                        1'b1, 1'b0, 1'b0, 1'b0, 8, 1, 0};

        repeat (2) cycle();
        check_all_zero("reset");
        reset_n = 1'b1;
        cycle();

        reset_mid_frame();
        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        spurious_test();
        v = vecs[0];
        v.exp_err = 1;
        run_frame(v);

        reset_n = 1'b0;
        #1;
        check_all_zero("final_reset");
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
